// File: rtl/stb_dcache_arbiter.sv
// Arbitrates store-buffer drains and LSU loads onto the single dcache port.
// Holds the granted request until the dcache acks; bounds store starvation.
module stb_dcache_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int BYTE_SEL_WIDTH = 4,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      stb2dcache_req,
  input  logic [ADDR_WIDTH-1:0]     stb2dcache_addr,
  input  logic [DATA_WIDTH-1:0]     stb2dcache_wdata,
  input  logic [BYTE_SEL_WIDTH-1:0] stb2dcache_sel_byte,
  input  logic                      stb2dcache_w_en,
  input  logic                      stb_full,
  output logic                      arb2stb_ack,
  input  logic                      lsudbus2arb_ld_req,
  input  logic [ADDR_WIDTH-1:0]     lsudbus2arb_ld_addr,
  output logic                      arb2lsudbus_ld_ack,
  output logic [DATA_WIDTH-1:0]     arb2lsudbus_ld_rdata,
  output logic                      arb2dcache_req,
  output logic [ADDR_WIDTH-1:0]     arb2dcache_addr,
  output logic [DATA_WIDTH-1:0]     arb2dcache_wdata,
  output logic [BYTE_SEL_WIDTH-1:0] arb2dcache_sel_byte,
  output logic                      arb2dcache_w_en,
  input  logic                      dcache2arb_ack,
  input  logic [DATA_WIDTH-1:0]     dcache2arb_rdata
);

  typedef enum logic [1:0] {IDLE, ST_BUSY, LD_BUSY} state_e;

  localparam int            CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  state_e                    state_q, state_d;
  logic [CW-1:0]             starve_cnt_q, starve_cnt_d;
  logic                      req_q, req_d;
  logic                      wen_q, wen_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [BYTE_SEL_WIDTH-1:0] sel_q, sel_d;

  // Write enable is implied by stb2dcache_req; kept only as a port.
  logic unused_w_en;
  assign unused_w_en = stb2dcache_w_en;

  logic raw_hit, st_win;
  assign raw_hit = lsudbus2arb_ld_req &&
                   (lsudbus2arb_ld_addr[ADDR_WIDTH-1:2] == stb2dcache_addr[ADDR_WIDTH-1:2]);
  assign st_win  = stb2dcache_req &&
                   (stb_full || (starve_cnt_q == LIMIT) || !lsudbus2arb_ld_req || raw_hit);

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    req_d        = req_q;
    wen_d        = wen_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    sel_d        = sel_q;
    case (state_q)
      IDLE: begin
        if (st_win) begin
          state_d      = ST_BUSY;
          starve_cnt_d = '0;
          req_d        = 1'b1;
          wen_d        = 1'b1;
          addr_d       = stb2dcache_addr;
          wdata_d      = stb2dcache_wdata;
          sel_d        = stb2dcache_sel_byte;
        end else if (lsudbus2arb_ld_req) begin
          state_d = LD_BUSY;
          req_d   = 1'b1;
          wen_d   = 1'b0;
          addr_d  = lsudbus2arb_ld_addr;
          wdata_d = '0;
          sel_d   = '1;
          // Only loads that bypass a waiting store count toward starvation.
          if (stb2dcache_req && starve_cnt_q != LIMIT) starve_cnt_d = starve_cnt_q + CW'(1);
        end
      end
      ST_BUSY, LD_BUSY: begin
        if (dcache2arb_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
          wen_d   = 1'b0;
          addr_d  = '0;
          wdata_d = '0;
          sel_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      req_q        <= 1'b0;
      wen_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      sel_q        <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      req_q        <= req_d;
      wen_q        <= wen_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      sel_q        <= sel_d;
    end
  end

  // Source acks are suppressed while reset is held so an aborted transfer never commits.
  assign arb2stb_ack          = rst_n && (state_q == ST_BUSY) && dcache2arb_ack;
  assign arb2lsudbus_ld_ack   = rst_n && (state_q == LD_BUSY) && dcache2arb_ack;
  assign arb2lsudbus_ld_rdata = arb2lsudbus_ld_ack ? dcache2arb_rdata : '0;

  assign arb2dcache_req      = req_q;
  assign arb2dcache_w_en     = wen_q;
  assign arb2dcache_addr     = addr_q;
  assign arb2dcache_wdata    = wdata_q;
  assign arb2dcache_sel_byte = sel_q;

endmodule

// File: tb/tb_stb_dcache_arbiter.sv
// Scoreboard bench for stb_dcache_arbiter: expected dcache transactions are queued
// in hand-computed grant order and a monitor checks each one as it appears.
module tb_stb_dcache_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stb2dcache_req;
  logic [31:0] stb2dcache_addr, stb2dcache_wdata;
  logic [3:0]  stb2dcache_sel_byte;
  logic        stb2dcache_w_en;
  logic        stb_full;
  logic        arb2stb_ack;
  logic        lsudbus2arb_ld_req;
  logic [31:0] lsudbus2arb_ld_addr;
  logic        arb2lsudbus_ld_ack;
  logic [31:0] arb2lsudbus_ld_rdata;
  logic        arb2dcache_req;
  logic [31:0] arb2dcache_addr, arb2dcache_wdata;
  logic [3:0]  arb2dcache_sel_byte;
  logic        arb2dcache_w_en;
  logic        dcache2arb_ack;
  logic [31:0] dcache2arb_rdata;

  stb_dcache_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BYTE_SEL_WIDTH(4), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .stb2dcache_req(stb2dcache_req), .stb2dcache_addr(stb2dcache_addr),
    .stb2dcache_wdata(stb2dcache_wdata), .stb2dcache_sel_byte(stb2dcache_sel_byte),
    .stb2dcache_w_en(stb2dcache_w_en), .stb_full(stb_full), .arb2stb_ack(arb2stb_ack),
    .lsudbus2arb_ld_req(lsudbus2arb_ld_req), .lsudbus2arb_ld_addr(lsudbus2arb_ld_addr),
    .arb2lsudbus_ld_ack(arb2lsudbus_ld_ack), .arb2lsudbus_ld_rdata(arb2lsudbus_ld_rdata),
    .arb2dcache_req(arb2dcache_req), .arb2dcache_addr(arb2dcache_addr),
    .arb2dcache_wdata(arb2dcache_wdata), .arb2dcache_sel_byte(arb2dcache_sel_byte),
    .arb2dcache_w_en(arb2dcache_w_en), .dcache2arb_ack(dcache2arb_ack),
    .dcache2arb_rdata(dcache2arb_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic w; logic [31:0] a; logic [31:0] d; logic [3:0] s; logic [31:0] r;} exp_t;
  typedef struct packed {logic [31:0] a; logic [31:0] d; logic [3:0] s;} st_t;

  exp_t        exp_q[$];
  exp_t        cur;
  bit          act;
  st_t         st_q[$];
  logic [31:0] ld_q[$];
  int          n_chk = 0, n_fail = 0, done_cnt = 0, tgt = 0;
  bit          mon_en = 0, dc_en = 1, force_ack = 0;
  int          dc_lat = 0, wc = 0;
  bit          given = 0;
  logic [31:0] dc_rdata = 32'h0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  task automatic push_st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    exp_t e;
    e = '{w: 1'b1, a: a, d: d, s: s, r: 32'h0};
    exp_q.push_back(e);
  endtask

  task automatic push_ld(input logic [31:0] a, input logic [31:0] r);
    exp_t e;
    e = '{w: 1'b0, a: a, d: 32'h0, s: 4'hF, r: r};
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("completion_count", done_cnt, target);
    repeat (2) @(negedge clk);
    #1;
  endtask

  // dcache model: acks dc_lat cycles after req first seen; rdata is junk except on ack.
  always @(negedge clk) begin
    dcache2arb_ack   = 1'b0;
    dcache2arb_rdata = 32'hBAD0BAD0;
    if (!arb2dcache_req) begin
      wc = 0;
      given = 0;
    end else if (dc_en && !given) begin
      if (wc == dc_lat) begin
        dcache2arb_ack   = 1'b1;
        dcache2arb_rdata = dc_rdata;
        given = 1;
      end else wc++;
    end
    if (force_ack) begin
      dcache2arb_ack   = 1'b1;
      dcache2arb_rdata = dc_rdata;
    end
  end

  // Source models: hold the head request until its ack, then advance.
  always @(negedge clk) begin
    #3;
    if (arb2stb_ack && st_q.size() > 0) void'(st_q.pop_front());
    if (arb2lsudbus_ld_ack && ld_q.size() > 0) void'(ld_q.pop_front());
    stb2dcache_req      = st_q.size() > 0;
    stb2dcache_w_en     = st_q.size() > 0;
    stb2dcache_addr     = st_q.size() > 0 ? st_q[0].a : 32'h0;
    stb2dcache_wdata    = st_q.size() > 0 ? st_q[0].d : 32'h0;
    stb2dcache_sel_byte = st_q.size() > 0 ? st_q[0].s : 4'h0;
    lsudbus2arb_ld_req  = ld_q.size() > 0;
    lsudbus2arb_ld_addr = ld_q.size() > 0 ? ld_q[0] : 32'h0;
  end

  // Monitor: pops an expectation per new dcache request and checks the ack cycle.
  always @(negedge clk) begin
    #2;
    if (mon_en) begin
      if (!arb2dcache_req) act = 0;
      else if (!act) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_req: got addr %h expected no request", arb2dcache_addr);
        end else begin
          cur = exp_q.pop_front();
          act = 1;
          chk("req_w_en", {31'h0, arb2dcache_w_en}, {31'h0, cur.w});
          chk("req_addr", arb2dcache_addr, cur.a);
          chk("req_wdata", arb2dcache_wdata, cur.d);
          chk("req_sel", {28'h0, arb2dcache_sel_byte}, {28'h0, cur.s});
        end
      end
      if (act) begin
        chk("hold_addr", arb2dcache_addr, cur.a);
        if (dcache2arb_ack) begin
          chk("stb_ack", {31'h0, arb2stb_ack}, {31'h0, cur.w});
          chk("ld_ack", {31'h0, arb2lsudbus_ld_ack}, {31'h0, !cur.w});
          chk("ld_rdata", arb2lsudbus_ld_rdata, cur.w ? 32'h0 : cur.r);
          done_cnt++;
        end
      end else begin
        chk("idle_stb_ack", {31'h0, arb2stb_ack}, 32'h0);
        chk("idle_ld_ack", {31'h0, arb2lsudbus_ld_ack}, 32'h0);
        chk("idle_rdata", arb2lsudbus_ld_rdata, 32'h0);
        chk("idle_addr", arb2dcache_addr, 32'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0;
    stb_full = 1'b0;
    stb2dcache_req = 0; stb2dcache_w_en = 0; stb2dcache_addr = 0; stb2dcache_wdata = 0;
    stb2dcache_sel_byte = 0; lsudbus2arb_ld_req = 0; lsudbus2arb_ld_addr = 0;
    dcache2arb_ack = 0; dcache2arb_rdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    rst_n = 1'b1;
    chk("rst_req", {31'h0, arb2dcache_req}, 32'h0);
    chk("rst_w_en", {31'h0, arb2dcache_w_en}, 32'h0);
    chk("rst_addr", arb2dcache_addr, 32'h0);
    chk("rst_wdata", arb2dcache_wdata, 32'h0);
    chk("rst_sel", {28'h0, arb2dcache_sel_byte}, 32'h0);
    chk("rst_ld_rdata", arb2lsudbus_ld_rdata, 32'h0);
    chk("rst_starve", 32'(dut.starve_cnt_q), 32'h0);
    mon_en = 1;

    // Store only, dcache answers 2 cycles after req.
    dc_lat = 2;
    push_st(32'h100, 32'hDEADBEEF, 4'hF);
    st_q.push_back('{a: 32'h100, d: 32'hDEADBEEF, s: 4'hF});
    tgt += 1; wait_done(tgt);

    // Load only.
    dc_lat = 1; dc_rdata = 32'h12345678;
    push_ld(32'h200, 32'h12345678);
    ld_q.push_back(32'h200);
    tgt += 1; wait_done(tgt);

    // Starvation: 4 loads bypass the store, then it is forced, then the last load.
    dc_lat = 0; dc_rdata = 32'hCAFE0400;
    repeat (4) push_ld(32'h400, 32'hCAFE0400);
    push_st(32'h300, 32'hA5A5A5A5, 4'hF);
    push_ld(32'h400, 32'hCAFE0400);
    st_q.push_back('{a: 32'h300, d: 32'hA5A5A5A5, s: 4'hF});
    repeat (5) ld_q.push_back(32'h400);
    tgt += 6; wait_done(tgt);
    chk("starve_after", 32'(dut.starve_cnt_q), 32'h0);

    // Same-word hazard: store drains before the load.
    dc_rdata = 32'h0BADF00D;
    push_st(32'h500, 32'h11112222, 4'h3);
    push_ld(32'h502, 32'h0BADF00D);
    st_q.push_back('{a: 32'h500, d: 32'h11112222, s: 4'h3});
    ld_q.push_back(32'h502);
    tgt += 2; wait_done(tgt);

    // Both pending, no forcing condition: load first.
    dc_rdata = 32'h99990900;
    push_ld(32'h900, 32'h99990900);
    push_st(32'h800, 32'h80808080, 4'hC);
    st_q.push_back('{a: 32'h800, d: 32'h80808080, s: 4'hC});
    ld_q.push_back(32'h900);
    tgt += 2; wait_done(tgt);

    // Store buffer full: store first.
    stb_full = 1'b1; dc_rdata = 32'h77770700;
    push_st(32'h600, 32'h66666666, 4'h1);
    push_ld(32'h700, 32'h77770700);
    st_q.push_back('{a: 32'h600, d: 32'h66666666, s: 4'h1});
    ld_q.push_back(32'h700);
    tgt += 2; wait_done(tgt);
    stb_full = 1'b0;

    // Reset while a store is outstanding; the late dcache ack must be ignored.
    dc_en = 0;
    push_st(32'hA00, 32'hFEEDFACE, 4'hF);
    st_q.push_back('{a: 32'hA00, d: 32'hFEEDFACE, s: 4'hF});
    n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (!arb2dcache_req && n < 20);
    chk("busy_before_reset", {31'h0, arb2dcache_req}, 32'h1);
    rst_n = 1'b0;
    st_q.delete();
    @(negedge clk); #1;
    chk("abort_req", {31'h0, arb2dcache_req}, 32'h0);
    chk("abort_w_en", {31'h0, arb2dcache_w_en}, 32'h0);
    chk("abort_addr", arb2dcache_addr, 32'h0);
    chk("abort_wdata", arb2dcache_wdata, 32'h0);
    chk("abort_sel", {28'h0, arb2dcache_sel_byte}, 32'h0);
    chk("abort_starve", 32'(dut.starve_cnt_q), 32'h0);
    rst_n = 1'b1;
    force_ack = 1;
    @(negedge clk); #3;
    chk("late_ack_stb_ack", {31'h0, arb2stb_ack}, 32'h0);
    force_ack = 0;
    @(negedge clk); #1;
    chk("late_ack_req", {31'h0, arb2dcache_req}, 32'h0);
    dc_en = 1;
    repeat (2) @(negedge clk);

    chk("scoreboard_empty", exp_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
